shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, fully pipelined barrel shifter and rotator for the ALU/execute path. It is the successor to the single-cycle 32-bit shifter. It adds generic data width, a rotate-right mode, a pass-through tag, and a valid/ready handshake with backpressure and flush. Multi-cycle shift traffic can therefore be decoupled from the main datapath.

## Interface
Parameters:
- WIDTH, default 32: data width. Must be a power of two, at least 4.
- TAG_W, default 5: width of the opaque tag carried with each operation, e.g. a destination register index.
- Derived, not overridable: SHW = log2(WIDTH), the shift-amount width and the number of pipeline levels.

Ports (clock and reset first):
- clk, in, 1: sole clock. All state changes on the rising edge.
- reset, in, 1: asynchronous, active-high. Clears all state.
- flush, in, 1: synchronous. Kills every in-flight operation.
- in_valid, in, 1: request present.
- in_ready, out, 1: stage 0 can accept the request this cycle.
- in_data, in, WIDTH: operand to shift.
- in_shamt, in, SHW: shift amount. Only the low SHW bits exist; there is no over-range shift.
- in_mode, in, 2: operation code. 00 SLL, 01 SRL, 10 ROR, 11 SRA.
- in_tag, in, TAG_W: passed through unchanged.
- out_valid, out, 1: result present.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, WIDTH: shifted result.
- out_zero, out, 1: high when out_data is all zeros.
- out_tag, out, TAG_W: tag of the result.

## Operation
- There are SHW levels. Level k (k = 0..SHW-1) handles shift distance 2^(SHW-1-k), largest first, under control of shamt bit SHW-1-k. If that bit is 0, the data passes through unchanged.
- Mode behaviour at each level, for distance d:
  - SLL: shift left, fill with zeros.
  - SRL: shift right, fill with zeros.
  - SRA: shift right, fill with the sign bit of the original operand. The sign is captured at entry and carried down the pipe, not read from the intermediate value.
  - ROR: rotate right, low d bits move into the top.
- Each level has a register slot containing valid, data, mode, the remaining shamt bits, sign and tag. The last slot drives the out_* ports directly.
- Slot k advances when valid_k is high and ready_{k+1} is high. Ready rules:
  - ready_k = !valid_k || ready_{k+1}
  - ready_SHW = out_ready
  - in_ready = ready_0
- The ready chain is combinational. No combinational path from in_valid to out_valid.
- out_zero is computed combinationally from the final slot's data.
- flush clears every valid bit on the next edge and overrides any acceptance in the same cycle: an input presented with flush high is dropped. Data registers may keep stale contents.
- Reset values: all valid bits 0, all data/tag/mode/shamt registers 0, so out_valid = 0, out_data = 0, out_zero = 1, out_tag = 0. in_ready = 1 whenever the pipe is empty.

## Timing
- Latency: a request accepted on edge N is presented with out_valid = 1 after edge N+SHW (5 cycles at WIDTH = 32), provided there is no backpressure.
- Throughput: one operation per cycle while out_ready stays high.
- Backpressure: with out_ready low, the pipe fills one slot per cycle. in_ready drops in the cycle where all SHW slots are valid and out_ready is low. No data is lost or duplicated.
- Bubbles collapse: an empty slot accepts from upstream even if downstream is stalled.
- Output stability: while out_valid is high and out_ready is low, out_data, out_tag and out_zero hold stable.
- Reset asserted mid-operation: all slots are invalid immediately, asynchronously. After deassertion the first acceptance is possible on the next rising edge.
- Simultaneous flush and out_ready: the result currently on the output is considered consumed only if out_valid and out_ready are both high in that cycle. The block's state after the edge is empty either way.

## Structure
- Shared ALU package holds the mode constants (SHIFT_SLL = 2'b00, SHIFT_SRL = 2'b01, SHIFT_ROR = 2'b10, SHIFT_SRA = 2'b11). The existing 32-bit shifter encoding is kept for 00/01/11.
- One sub-module, shift_pipe_level, parameterised by WIDTH, TAG_W and DIST. It contains one combinational level plus its register slot and handshake. shift_pipe instantiates SHW of these in a generate loop.

## Test plan
- Reset then single ops, WIDTH = 32:
  - SLL 0x0000_0001 by 31 gives 0x8000_0000.
  - SRA 0x8000_0000 by 4 gives 0xF800_0000.
  - SRL 0x8000_0000 by 4 gives 0x0800_0000.
  - ROR 0x0000_00F1 by 4 gives 0x1000_000F.
  - Each result appears exactly 5 cycles after acceptance.
- Zero and tag: SRL 0x0000_000F by 4 gives out_data 0, out_zero = 1, and out_tag equal to in_tag (e.g. 5'h1A).
- Streaming: 100 random back-to-back ops with out_ready held high. in_ready stays 1, one result per cycle, order preserved, all results match the reference model.
- Backpressure: hold out_ready low for 8 cycles while sending continuously. Exactly 5 ops are accepted, in_ready falls, out_data stays stable. Release out_ready; results drain in order with no loss.
- Flush with 3 ops in flight and a 4th presented: no out_valid follows the flush, and the next op after flush emerges at normal latency.
- WIDTH = 8 instance: ROR 0x81 by 1 gives 0xC0, and latency is 3 cycles. Assert reset mid-stream; out_valid drops immediately and the next accepted op completes correctly.

Source files
------------

// File: rtl/shift_pipe_pkg.sv
// Shared ALU definitions used by the pipelined shifter.
// Encodings 00/01/11 match the older single-cycle shifter.
package shift_pipe_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_ROR = 2'b10,
        SHIFT_SRA = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shift_pipe_level.sv
// One shifter level: a fixed-distance shift/rotate feeding a register slot
// with an elastic valid/ready handshake.
module shift_pipe_level
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int DIST  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [WIDTH-1:0]         up_data,
    input  logic [1:0]               up_mode,
    input  logic [$clog2(WIDTH)-1:0] up_shamt,
    input  logic                     up_sign,
    input  logic [TAG_W-1:0]         up_tag,
    output logic                     dn_valid,
    input  logic                     dn_ready,
    output logic [WIDTH-1:0]         dn_data,
    output logic [1:0]               dn_mode,
    output logic [$clog2(WIDTH)-1:0] dn_shamt,
    output logic                     dn_sign,
    output logic [TAG_W-1:0]         dn_tag
);

    localparam int BIT = $clog2(DIST);

    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] shifted;

    // SRA fills from the sign captured at entry, not the current data.
    always_comb begin
        fill    = {WIDTH{up_sign}} << (WIDTH - DIST);
        shifted = up_data;
        if (up_shamt[BIT]) begin
            unique case (shift_mode_e'(up_mode))
                SHIFT_SLL: shifted = up_data << DIST;
                SHIFT_SRL: shifted = up_data >> DIST;
                SHIFT_ROR: shifted = (up_data >> DIST)
                                   | (up_data << (WIDTH - DIST));
                SHIFT_SRA: shifted = fill | (up_data >> DIST);
            endcase
        end
    end

    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_mode  <= '0;
            dn_shamt <= '0;
            dn_sign  <= 1'b0;
            dn_tag   <= '0;
        end else if (flush) begin
            dn_valid <= 1'b0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data  <= shifted;
                dn_mode  <= up_mode;
                dn_shamt <= up_shamt;
                dn_sign  <= up_sign;
                dn_tag   <= up_tag;
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Fully pipelined barrel shifter/rotator, one level per shamt bit,
// largest distance first, with backpressure and flush.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zero,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW:0]                 valid;
    logic [SHW:0]                 ready;
    logic [SHW:0]                 sign;
    logic [SHW:0][WIDTH-1:0]      data;
    logic [SHW:0][1:0]            mode;
    logic [SHW:0][SHW-1:0]        shamt;
    logic [SHW:0][TAG_W-1:0]      tag;

    assign valid[0]   = in_valid;
    assign data[0]    = in_data;
    assign mode[0]    = in_mode;
    assign shamt[0]   = in_shamt;
    assign sign[0]    = in_data[WIDTH-1];
    assign tag[0]     = in_tag;
    assign ready[SHW] = out_ready;
    assign in_ready   = ready[0];

    for (genvar k = 0; k < SHW; k++) begin : g_level
        shift_pipe_level #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .DIST  (1 << (SHW - 1 - k))
        ) u_level (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .up_valid (valid[k]),
            .up_ready (ready[k]),
            .up_data  (data[k]),
            .up_mode  (mode[k]),
            .up_shamt (shamt[k]),
            .up_sign  (sign[k]),
            .up_tag   (tag[k]),
            .dn_valid (valid[k+1]),
            .dn_ready (ready[k+1]),
            .dn_data  (data[k+1]),
            .dn_mode  (mode[k+1]),
            .dn_shamt (shamt[k+1]),
            .dn_sign  (sign[k+1]),
            .dn_tag   (tag[k+1])
        );
    end

    assign out_valid = valid[SHW];
    assign out_data  = data[SHW];
    assign out_zero  = ~|data[SHW];
    assign out_tag   = tag[SHW];

    // Control fields are spent by the time the last slot is reached.
    logic unused_tail;
    assign unused_tail = ^{shamt[SHW], mode[SHW], sign[SHW]};

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: queue model for the 32-bit instance plus
// directed literal checks on 32-bit and 8-bit instances.
module tb_shift_pipe;

    localparam int SHW = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_zero;
    logic [4:0]  out_tag;

    logic        rst8 = 1'b1;
    logic        v8 = 1'b0;
    logic        rdy8;
    logic [7:0]  d8 = '0;
    logic [2:0]  s8 = '0;
    logic [1:0]  m8 = '0;
    logic [4:0]  t8 = '0;
    logic        ov8;
    logic        or8 = 1'b1;
    logic [7:0]  od8;
    logic        oz8;
    logic [4:0]  ot8;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .reset(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_tag(out_tag)
    );

    shift_pipe #(.WIDTH(8), .TAG_W(5)) dut8 (
        .clk(clk), .reset(rst8), .flush(1'b0),
        .in_valid(v8), .in_ready(rdy8),
        .in_data(d8), .in_shamt(s8),
        .in_mode(m8), .in_tag(t8),
        .out_valid(ov8), .out_ready(or8),
        .out_data(od8), .out_zero(oz8), .out_tag(ot8)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_out = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref32(input logic [31:0] d,
                                          input int s,
                                          input logic [1:0] m);
        logic [63:0] dd;
        dd = {d, d} >> s;
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return dd[31:0];
            default: return $unsigned($signed(d) >>> s);
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
        logic [31:0] c;
    } exp_t;

    exp_t        q[$];
    logic        held = 1'b0;
    logic [31:0] hold_d;
    logic [4:0]  hold_t;
    logic        hold_z;

    // The oldest op has nothing ahead of it, so it reaches the output
    // exactly SHW cycles after acceptance regardless of stalls.
    always @(negedge clk) begin
        logic ev;
        cyc++;
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            ev = (q.size() > 0) && (cyc - int'(q[0].c) >= SHW);
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("in_ready", 32'(in_ready),
                32'(!(q.size() == SHW && !out_ready)));
            if (out_valid && ev) begin
                chk("out_data", out_data, q[0].d);
                chk("out_zero", 32'(out_zero), 32'(q[0].d == 0));
                chk("out_tag", 32'(out_tag), 32'(q[0].t));
            end
            if (held && out_valid) begin
                chk("hold_data", out_data, hold_d);
                chk("hold_tag", 32'(out_tag), 32'(hold_t));
                chk("hold_zero", 32'(out_zero), 32'(hold_z));
            end
            held   = out_valid && !out_ready;
            hold_d = out_data;
            hold_t = out_tag;
            hold_z = out_zero;
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                n_out++;
            end
            if (flush) begin
                q.delete();
                held = 1'b0;
            end else if (in_valid && in_ready) begin
                q.push_back('{ref32(in_data, int'(in_shamt), in_mode),
                              in_tag, 32'(cyc)});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op32(input string nm, input logic [31:0] d,
                        input logic [4:0] s, input logic [1:0] m,
                        input logic [4:0] t, input logic [31:0] exp);
        int lat;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        in_tag   = t;
        tick();
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(SHW));
        chk(nm, out_data, exp);
        chk({nm, "_zero"}, 32'(out_zero), 32'(exp == 0));
        chk({nm, "_tag"}, 32'(out_tag), 32'(t));
        tick();
    endtask

    task automatic op8(input string nm, input logic [7:0] d,
                       input logic [2:0] s, input logic [1:0] m,
                       input logic [4:0] t, input logic [7:0] exp);
        int lat;
        v8 = 1'b1;
        d8 = d;
        s8 = s;
        m8 = m;
        t8 = t;
        tick();
        v8 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ov8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'd3);
        chk(nm, 32'(od8), 32'(exp));
        chk({nm, "_zero"}, 32'(oz8), 32'(exp == 0));
        chk({nm, "_tag"}, 32'(ot8), 32'(t));
        tick();
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        chk(nm, 32'(q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int base;
        int seen;

        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd1);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst8_zero", 32'(oz8), 32'd1);
        tick();

        op32("sll31", 32'h0000_0001, 5'd31, 2'b00, 5'h01, 32'h8000_0000);
        op32("sra4", 32'h8000_0000, 5'd4, 2'b11, 5'h02, 32'hF800_0000);
        op32("srl4", 32'h8000_0000, 5'd4, 2'b01, 5'h03, 32'h0800_0000);
        op32("ror4", 32'h0000_00F1, 5'd4, 2'b10, 5'h04, 32'h1000_000F);
        op32("zero", 32'h0000_000F, 5'd4, 2'b01, 5'h1A, 32'h0000_0000);

        base = n_out;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_shamt = 5'($urandom_range(0, 31));
            in_mode  = 2'($urandom_range(0, 3));
            in_tag   = 5'($urandom_range(0, 31));
            tick();
        end
        in_valid = 1'b0;
        drain("stream_drain");
        chk("stream_count", 32'(n_out - base), 32'd100);

        out_ready = 1'b0;
        acc = 0;
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i);
            in_shamt = 5'(i);
            in_mode  = 2'b00;
            in_tag   = 5'(i);
            @(negedge clk);
            if (in_ready) acc++;
            if (i == 7) begin
                chk("bp_ready_low", 32'(in_ready), 32'd0);
                chk("bp_hold", out_data, 32'h100);
            end
            tick();
        end
        chk("bp_accepted", 32'(acc), 32'd5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_count", 32'(n_out - base), 32'd5);

        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA5A5_0000 + 32'(i);
            in_shamt = 5'd1;
            in_mode  = 2'b01;
            in_tag   = 5'(i + 8);
            flush    = (i == 3);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
            tick();
        end
        chk("flush_quiet", 32'(seen), 32'd0);
        op32("post_flush", 32'hFFFF_0000, 5'd16, 2'b01, 5'h07,
             32'h0000_FFFF);

        op8("w8_ror1", 8'h81, 3'd1, 2'b10, 5'h03, 8'hC0);
        for (int i = 0; i < 4; i++) begin
            v8 = 1'b1;
            d8 = 8'(i + 1);
            s8 = 3'd0;
            m8 = 2'b00;
            t8 = 5'(i);
            tick();
        end
        v8 = 1'b0;
        chk("w8_pre_rst_valid", 32'(ov8), 32'd1);
        #2 rst8 = 1'b1;
        #1;
        chk("w8_rst_valid", 32'(ov8), 32'd0);
        chk("w8_rst_ready", 32'(rdy8), 32'd1);
        @(posedge clk);
        #1 rst8 = 1'b0;
        op8("w8_sra2", 8'h90, 3'd2, 2'b11, 5'h04, 8'hE4);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
